// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: instruction-fetch and data-memory handshake bundle between controller and memories
interface cpu_ctrl_fsm_if #(parameter int DATAWIDTH = 16);
  logic                 instr_req;
  logic [DATAWIDTH-1:0] instr_addr;
  logic                 instr_ack;
  logic [15:0]          instr_data;
  logic                 mem_req;
  logic                 mem_we;
  logic [DATAWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 mem_ack;
  modport master (
    output instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  instr_ack, instr_data, mem_ack
  );
  modport slave (
    input  instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output instr_ack, instr_data, mem_ack
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle fetch/decode/exec/mem controller for the 16-bit datapath.
// Defining CPU_CTRL_PERF_EN adds cyc_cnt/ret_cnt performance counters.
module cpu_ctrl_fsm #(
  parameter int DATAWIDTH  = 16,
  parameter int REGWIDTH   = 4,
  parameter int ALUOPWIDTH = 4,
  parameter int IMMWIDTH   = 8,
  parameter int PSRWIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_ctrl_fsm_if.master        bus,
  input  logic [DATAWIDTH-1:0]  dSrc,
  input  logic [DATAWIDTH-1:0]  dDst,
  input  logic [PSRWIDTH-1:0]   psrOut,
  output logic                  write,
  output logic                  IMM_MUX,
  output logic                  COND_RSLT,
  output logic                  WB_MUX0,
  output logic [1:0]            WB_MUX,
  output logic [REGWIDTH-1:0]   rSrc,
  output logic [REGWIDTH-1:0]   rDst,
  output logic [ALUOPWIDTH-1:0] aluOp,
  output logic [IMMWIDTH-1:0]   imm_in,
  output logic [DATAWIDTH-1:0]  pc_ra,
  output logic                  illegal
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0]           cyc_cnt,
  output logic [31:0]           ret_cnt
`endif
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, MEM} state_t;
  state_t               state, state_nxt;
  logic [15:0]          ir;
  logic [DATAWIDTH-1:0] pc, pc_nxt, addr_q, wdata_q;
  logic [PSRWIDTH-1:0]  psr_q;
  logic                 pc_upd;
  logic [3:0]           op, sub;
  logic                 is_alu, is_load, is_stor, is_jal, is_jc, is_sc, is_mem, is_ill;
  // psr bits: 0 C, 1 L, 2 F, 3 Z, 4 N; odd codes test the negated flag
  function automatic logic cond_eval(input logic [3:0] c, input logic [PSRWIDTH-1:0] p);
    logic f;
    f = c[3:1] == 3'd0 ? p[3] :
        c[3:1] == 3'd1 ? p[0] :
        c[3:1] == 3'd2 ? p[1] :
        c[3:1] == 3'd3 ? p[4] :
        c[3:1] == 3'd4 ? p[2] : 1'b0;
    return c == 4'hE ? 1'b1 : c < 4'd10 ? f ^ c[0] : 1'b0;
  endfunction
  assign op        = ir[15:12];
  assign sub       = ir[7:4];
  assign is_alu    = op == 4'h0 || ir[15];
  assign is_load   = op == 4'h4 && sub == 4'h0;
  assign is_stor   = op == 4'h4 && sub == 4'h4;
  assign is_jal    = op == 4'h4 && sub == 4'h8;
  assign is_jc     = op == 4'h4 && sub == 4'hC;
  assign is_sc     = op == 4'h4 && sub == 4'hD;
  assign is_mem    = is_load || is_stor;
  assign is_ill    = !(is_alu || is_mem || is_jal || is_jc || is_sc);
  assign COND_RSLT = cond_eval(is_jc ? ir[11:8] : ir[3:0], psr_q);
  assign rDst      = REGWIDTH'(ir[11:8]);
  assign rSrc      = REGWIDTH'(ir[3:0]);
  assign aluOp     = ir[15] ? ALUOPWIDTH'({1'b0, ir[14:12]}) : ALUOPWIDTH'(sub);
  assign IMM_MUX   = ir[15];
  assign imm_in    = IMMWIDTH'(ir[7:0]);
  assign WB_MUX0   = 1'b0;
  assign WB_MUX    = is_load ? 2'd3 : is_sc ? 2'd1 : is_jal ? 2'd0 : 2'd2;
  assign pc_ra     = pc + DATAWIDTH'(1);
  assign bus.instr_addr = pc;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = is_stor;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      psr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && bus.instr_ack) ir <= bus.instr_data;
      if (state == EXEC && is_alu) psr_q <= psrOut;
      if (state == EXEC && is_mem) begin
        addr_q  <= dSrc;
        wdata_q <= dDst;
      end
      if (pc_upd) pc <= pc_nxt;
    end
  end
  always_comb begin
    state_nxt     = state;
    bus.instr_req = 1'b0;
    bus.mem_req   = 1'b0;
    write         = 1'b0;
    illegal       = 1'b0;
    pc_upd        = 1'b0;
    pc_nxt        = pc_ra;
    case (state)
      FETCH: begin
        bus.instr_req = 1'b1;
        state_nxt     = bus.instr_ack ? DECODE : FETCH;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = is_mem ? MEM : FETCH;
        pc_upd    = !is_mem;
        write     = is_alu || is_sc || is_jal;
        illegal   = is_ill;
        pc_nxt    = (is_jal || (is_jc && COND_RSLT)) ? dSrc : pc_ra;
      end
      MEM: begin
        bus.mem_req = 1'b1;
        write       = is_load && bus.mem_ack;
        pc_upd      = bus.mem_ack;
        state_nxt   = bus.mem_ack ? FETCH : MEM;
      end
    endcase
    // reset wins over every strobe, even before its first clock edge lands
    if (reset) begin
      bus.instr_req = 1'b0;
      bus.mem_req   = 1'b0;
      write         = 1'b0;
      illegal       = 1'b0;
    end
  end
`ifdef CPU_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (pc_upd) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif
endmodule
